// File: rtl/alu_pkg.sv
// Shared constants for the stream multiplexer slice.
// The mode encoding is common to the top level and the bench.
package alu_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins, wrapping modulo N.
// It has no state; the caller owns ptr and advances it only on a real transfer.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        // Search order is ptr+1, ptr+2, ..., ptr (ptr itself comes last).
        for (int unsigned k = 1; k <= N; k++) begin
            cand = SEL_W'((32'(ptr) + k) % N);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 valid/ready stream multiplexer with manual or round-robin channel selection.
// A single output register gives 1-cycle latency and full throughput.
module stream_mux_n_to_1
    import alu_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] chan_data [N];
    logic [WIDTH-1:0] sel_data;

    logic [SEL_W-1:0] ptr_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_chan_q;
    logic             out_valid_q;

    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;

    logic [N-1:0]     man_onehot;
    logic             sel_ok;
    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign chan_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N(N)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    assign load_en = !out_valid_q || out_ready;
    assign sel_ok  = 32'(sel) < N;

    // Manual mode grants sel regardless of in_valid; an out-of-range sel grants nothing.
    always_comb begin
        man_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            man_onehot[i] = (sel == SEL_W'(i));
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_oh  = rr_grant;
            grant_idx = rr_idx;
        end else begin
            grant_oh  = sel_ok ? man_onehot : '0;
            grant_idx = sel;
        end
    end

    // Gated by rst_n so no channel sees ready while reset is held.
    assign in_ready = (rst_n && load_en) ? grant_oh : '0;
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = chan_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SEL_W'(N - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_chan_q  <= grant_idx;
            ptr_q       <= grant_idx;
        end else if (load_en) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
    a_ready_load:   assert property (@(posedge clk) disable iff (!rst_n)
                                     (in_ready != '0) |-> load_en);

endmodule
